writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Registered writeback stage of the core.
- Selects the register-file write value from ALU result, formatted load data, PC+4 or CSR read data.
- Waits a variable number of cycles for the data-memory read response on loads, then issues a one-cycle register-file write.
- Sits between the memory-access logic and the register file. Generalises the earlier two-way load/ALU mux to XLEN 32/64, four sources, sub-word load extraction with sign/zero extension, and a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RADDR_W, 5, register-file address width.
- OFS_W, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_rd  in  RADDR_W  destination register
- in_wb_sel  in  2  0=ALU, 1=load, 2=PC+4, 3=CSR
- in_alu_result  in  XLEN  ALU result
- in_pc_plus4  in  XLEN  link value
- in_csr_data  in  XLEN  CSR read value
- in_funct3  in  3  load size/sign code
- in_byte_ofs  in  OFS_W  low address bits of the load
- mem_r_valid  in  1  read response valid
- mem_r_data  in  XLEN  read response, naturally aligned word/dword
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  write address
- rf_wdata  out  XLEN  write data
- busy  out  1  load outstanding

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0. in_ready is combinational (=IDLE), so it reads 1 after reset.
- States:
  - IDLE: in_ready=1. Accept occurs when in_valid=1 in this state.
  - WAIT_MEM: in_ready=0, busy=1.
- Non-load accept (wb_sel != 1): on the next edge, rf_we<=(in_rd!=0), rf_waddr<=in_rd, rf_wdata<=selected source. Latency is 1 cycle. State stays IDLE, so back-to-back accepts are allowed every cycle.
- Load accept (wb_sel == 1): capture rd, funct3 and byte_ofs; go to WAIT_MEM; rf_we<=0.
- WAIT_MEM with mem_r_valid=1: format mem_r_data; on the same edge, rf_we<=(rd!=0), rf_waddr<=rd, rf_wdata<=formatted; return to IDLE. A new accept is possible in the following cycle.
- WAIT_MEM with mem_r_valid=0: hold; rf_we=0. There is no timeout.
- mem_r_valid in IDLE is ignored. Responses are never earlier than the cycle after the load accept.
- rf_we is high for exactly one cycle per retired instruction. rf_waddr and rf_wdata hold their last values while rf_we=0.
- rd=0: the handshake and state sequence complete normally, but rf_we stays 0.
- Load formatting (byte lane = byte_ofs; halfword lane = byte_ofs with bit0 ignored; word lane = byte_ofs[OFS_W-1:2] for XLEN=64):
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend halfword.
  - 101 LHU: zero-extend halfword.
  - 010 LW: sign-extend word; identity for XLEN=32.
  - 110 LWU: zero-extend word.
  - 011 LD: full XLEN=64 data.
  - Any other code, and any XLEN=32 code outside LB/LBU/LH/LHU/LW: pass mem_r_data unmodified.
  - Misalignment is not detected here.
- Reset in WAIT_MEM: pending load is dropped, no write occurs, state returns to IDLE. A late mem_r_valid arriving afterwards is ignored.
- Reset has priority over accept and mem_r_valid in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles, then released -> rf_we=0, busy=0, in_ready=1, rf_wdata=0.
- ALU stream (XLEN=32): 3 back-to-back accepts, rd=1/2/3, alu=0x11/0x22/0x33 -> rf_we=1 on 3 consecutive cycles, each one cycle after accept, with matching data; in_ready stays 1.
- Load with stall: LB, byte_ofs=2, rd=5; mem_r_valid asserted 3 cycles later with data 0x12_80_34_56 -> in_ready=0 and busy=1 for 3 cycles; rf_wdata=0xFFFFFF80 one cycle after the response.
- Extension: same data with LBU ofs=2 -> 0x00000080; LHU ofs=2 -> 0x00001280; LH ofs=0 -> 0x00003456. With XLEN=64, data 0x8000_0000_0000_0001: LW ofs=4 -> 0xFFFFFFFF80000000; LWU ofs=4 -> 0x0000000080000000.
- Other sources: wb_sel=2, pc_plus4=0x104, rd=1 -> rf_wdata=0x104; wb_sel=3, csr=0xABCD -> 0xABCD; any instruction with rd=0 -> rf_we never asserted.
- Reset mid-load: assert rst during WAIT_MEM, then mem_r_valid=1 one cycle after reset deasserts -> no rf_we, in_ready=1, busy=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: picks ALU/load/PC+4/CSR value and issues one register-file write per instruction.
// Non-loads retire 1 cycle after accept; loads hold in_ready low (busy) until the read response arrives.
module writeback_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int OFS_W   = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_wb_sel,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic [XLEN-1:0]    in_csr_data,
  input  logic [2:0]         in_funct3,
  input  logic [OFS_W-1:0]   in_byte_ofs,
  input  logic               mem_r_valid,
  input  logic [XLEN-1:0]    mem_r_data,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [2:0]         funct3;
    logic [OFS_W-1:0]   ofs;
  } ld_meta_t;

  state_t             state_q, state_d;
  ld_meta_t           ld_q, ld_d;
  logic               we_d;
  logic [RADDR_W-1:0] waddr_d;
  logic [XLEN-1:0]    wdata_d;
  logic [XLEN-1:0]    src_val;
  logic [XLEN-1:0]    ld_fmt;
  logic [OFS_W-1:0]   h_ofs, w_ofs;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [31:0]        word_v;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_MEM);

  always_comb begin
    src_val = in_alu_result;
    case (in_wb_sel)
      2'd2:    src_val = in_pc_plus4;
      2'd3:    src_val = in_csr_data;
      default: src_val = in_alu_result;
    endcase
  end

  // Lane offsets are aligned down; for XLEN=32 the word lane mask clears every bit.
  always_comb begin
    h_ofs  = ld_q.ofs & ~OFS_W'(1);
    w_ofs  = ld_q.ofs & ~OFS_W'(3);
    byte_v = 8'(mem_r_data >> {ld_q.ofs, 3'b000});
    half_v = 16'(mem_r_data >> {h_ofs, 3'b000});
    word_v = 32'(mem_r_data >> {w_ofs, 3'b000});
    case (ld_q.funct3)
      3'b000:  ld_fmt = XLEN'($signed(byte_v));
      3'b100:  ld_fmt = XLEN'(byte_v);
      3'b001:  ld_fmt = XLEN'($signed(half_v));
      3'b101:  ld_fmt = XLEN'(half_v);
      3'b010:  ld_fmt = XLEN'($signed(word_v));
      3'b110:  ld_fmt = (XLEN == 64) ? XLEN'(word_v) : mem_r_data;
      default: ld_fmt = mem_r_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    we_d    = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_wb_sel == 2'd1) begin
            ld_d    = '{rd: in_rd, funct3: in_funct3, ofs: in_byte_ofs};
            state_d = WAIT_MEM;
          end else begin
            we_d    = (in_rd != '0);
            waddr_d = in_rd;
            wdata_d = src_val;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_r_valid) begin
          we_d    = (ld_q.rd != '0);
          waddr_d = ld_q.rd;
          wdata_d = ld_fmt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ld_q     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      rf_we    <= we_d;
      rf_waddr <= waddr_d;
      rf_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench: XLEN=32 and XLEN=64 instances driven in lockstep, writes checked against a queued reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [63:0] alu = '0, pc4 = '0, csr = '0, mdata = '0;
  logic [2:0]  funct3 = '0, byte_ofs = '0;
  logic        mem_r_valid = 1'b0;

  logic        in_ready32, rf_we32, busy32;
  logic [4:0]  rf_waddr32;
  logic [31:0] rf_wdata32;
  logic        in_ready64, rf_we64, busy64;
  logic [4:0]  rf_waddr64;
  logic [63:0] rf_wdata64;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    int          e;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  logic [4:0] ld_rd;
  logic [2:0] ld_f3, ld_ofs;

  writeback_stage #(.XLEN(32), .RADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_alu_result(alu[31:0]), .in_pc_plus4(pc4[31:0]),
    .in_csr_data(csr[31:0]), .in_funct3(funct3), .in_byte_ofs(byte_ofs[1:0]),
    .mem_r_valid(mem_r_valid), .mem_r_data(mdata[31:0]), .rf_we(rf_we32),
    .rf_waddr(rf_waddr32), .rf_wdata(rf_wdata32), .busy(busy32)
  );

  writeback_stage #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_alu_result(alu), .in_pc_plus4(pc4),
    .in_csr_data(csr), .in_funct3(funct3), .in_byte_ofs(byte_ofs),
    .mem_r_valid(mem_r_valid), .mem_r_data(mdata), .rf_we(rf_we64),
    .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64), .busy(busy64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    return v[bits-1] ? (v | ~m) : (v & m);
  endfunction

  // Reference load formatting from lane arithmetic.
  function automatic logic [63:0] model_fmt(input int xlen, input logic [2:0] f3,
                                            input logic [2:0] ofs_in, input logic [63:0] raw);
    logic [63:0] data, bv, hv, wv, res, mask;
    int ofs;
    mask = (xlen == 32) ? 64'hFFFF_FFFF : '1;
    data = raw & mask;
    ofs  = (xlen == 32) ? int'(ofs_in) % 4 : int'(ofs_in);
    bv   = (data >> (8 * ofs)) & 64'hFF;
    hv   = (data >> (8 * ((ofs / 2) * 2))) & 64'hFFFF;
    wv   = ((xlen == 64 && ofs >= 4) ? (data >> 32) : data) & 64'hFFFF_FFFF;
    case (f3)
      3'd0:    res = sx(bv, 8);
      3'd4:    res = bv;
      3'd1:    res = sx(hv, 16);
      3'd5:    res = hv;
      3'd2:    res = sx(wv, 32);
      3'd6:    res = (xlen == 64) ? wv : data;
      default: res = data;
    endcase
    return res & mask;
  endfunction

  task automatic push(input logic [4:0] rd, input logic [63:0] d32, input logic [63:0] d64, input int e);
    exp_t x;
    if (rd != 5'd0) begin
      x.rd = rd; x.d = d32 & 64'hFFFF_FFFF; x.e = e; q32.push_back(x);
      x.d = d64; q64.push_back(x);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [63:0] a,
                       input logic [63:0] p, input logic [63:0] c, input logic [2:0] f3,
                       input logic [2:0] ofs);
    logic [63:0] v;
    check("in_ready32_idle", 64'(in_ready32), 64'd1);
    check("in_ready64_idle", 64'(in_ready64), 64'd1);
    in_valid = 1'b1; in_wb_sel = sel; in_rd = rd; alu = a; pc4 = p; csr = c;
    funct3 = f3; byte_ofs = ofs;
    if (sel != 2'd1) begin
      v = (sel == 2'd0) ? a : (sel == 2'd2) ? p : c;
      push(rd, v, v, cyc + 1);
    end else begin
      ld_rd = rd; ld_f3 = f3; ld_ofs = ofs;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input int gap, input logic [63:0] d);
    for (int i = 0; i <= gap; i++) begin
      check("busy32_wait", 64'(busy32), 64'd1);
      check("in_ready64_wait", 64'(in_ready64), 64'd0);
      if (i < gap) begin
        @(posedge clk); #1;
      end
    end
    mem_r_valid = 1'b1; mdata = d;
    push(ld_rd, model_fmt(32, ld_f3, ld_ofs, d), model_fmt(64, ld_f3, ld_ofs, d), cyc + 1);
    @(posedge clk); #1;
    mem_r_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] ofs,
                      input int gap, input logic [63:0] d);
    issue(2'd1, rd, 64'h0, 64'h0, 64'h0, f3, ofs);
    respond(gap, d);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rf_we32) begin
      if (q32.size() == 0) check("wr32_unexpected", {59'd0, rf_waddr32}, 64'd0 - 64'd1);
      else begin
        x = q32.pop_front();
        check("wr32_addr", 64'(rf_waddr32), 64'(x.rd));
        check("wr32_data", 64'(rf_wdata32), x.d);
        check("wr32_cycle", 64'(cyc), 64'(x.e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rf_we64) begin
      if (q64.size() == 0) check("wr64_unexpected", {59'd0, rf_waddr64}, 64'd0 - 64'd1);
      else begin
        x = q64.pop_front();
        check("wr64_addr", 64'(rf_waddr64), 64'(x.rd));
        check("wr64_data", rf_wdata64, x.d);
        check("wr64_cycle", 64'(cyc), 64'(x.e));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_we32", 64'(rf_we32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_ready32", 64'(in_ready32), 64'd1);
    check("rst_wdata32", 64'(rf_wdata32), 64'd0);
    check("rst_waddr64", 64'(rf_waddr64), 64'd0);
    check("rst_wdata64", rf_wdata64, 64'd0);
    check("rst_busy64", 64'(busy64), 64'd0);

    // Back-to-back ALU results
    issue(2'd0, 5'd1, 64'h11, 64'h0, 64'h0, 3'd0, 3'd0);
    issue(2'd0, 5'd2, 64'h22, 64'h0, 64'h0, 3'd0, 3'd0);
    issue(2'd0, 5'd3, 64'h33, 64'h0, 64'h0, 3'd0, 3'd0);

    // Loads with stalls and extension variants
    load(5'd5, 3'b000, 3'd2, 2, 64'h1280_3456);
    load(5'd6, 3'b100, 3'd2, 0, 64'h1280_3456);
    load(5'd7, 3'b101, 3'd2, 1, 64'h1280_3456);
    load(5'd8, 3'b001, 3'd0, 0, 64'h1280_3456);
    load(5'd9, 3'b010, 3'd4, 0, 64'h8000_0000_0000_0001);
    load(5'd10, 3'b110, 3'd4, 3, 64'h8000_0000_0000_0001);
    load(5'd11, 3'b011, 3'd0, 0, 64'h8000_0000_0000_0001);
    load(5'd12, 3'b111, 3'd5, 0, 64'hDEAD_BEEF_CAFE_F00D);

    // Other sources and rd=0
    issue(2'd2, 5'd1, 64'h0, 64'h104, 64'h0, 3'd0, 3'd0);
    issue(2'd3, 5'd4, 64'h0, 64'h0, 64'hABCD, 3'd0, 3'd0);
    issue(2'd0, 5'd0, 64'h55, 64'h0, 64'h0, 3'd0, 3'd0);
    load(5'd0, 3'b000, 3'd1, 1, 64'hFFFF_FFFF);

    // Reset in the middle of a load, then a late response
    issue(2'd1, 5'd13, 64'h0, 64'h0, 64'h0, 3'd0, 3'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_r_valid = 1'b1; mdata = 64'h77;
    @(posedge clk); #1;
    mem_r_valid = 1'b0;
    check("midrst_ready32", 64'(in_ready32), 64'd1);
    check("midrst_busy32", 64'(busy32), 64'd0);
    check("midrst_busy64", 64'(busy64), 64'd0);

    // Random mix; stray mem_r_valid while idle must be ignored
    for (int n = 0; n < 300; n++) begin
      int idle;
      logic [1:0] sel;
      logic [4:0] rd;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        mem_r_valid = 1'($urandom_range(0, 1));
        mdata = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      mem_r_valid = 1'b0;
      sel = 2'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (sel == 2'd1)
        load(rd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
             {$urandom, $urandom});
      else
        issue(sel, rd, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain64", 64'(q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
